// File: rtl/wallace_pkg.sv
// Shared constants, FSM state type and bit-level adder helpers for the
// Wallace-tree multiply-accumulate slice.
package wallace_pkg;

  localparam int OPW   = 4;
  localparam int PRODW = 8;

  typedef enum logic {
    ACC,
    HOLD
  } mac_state_t;

  // Returns {carry, sum}.
  function automatic logic [1:0] full_add(input logic x, input logic y, input logic z);
    return {(x & y) | (x & z) | (y & z), x ^ y ^ z};
  endfunction

  function automatic logic [1:0] half_add(input logic x, input logic y);
    return {x & y, x ^ y};
  endfunction

endpackage

// File: rtl/wallace_multiplier.sv
// Combinational 4x4 unsigned Wallace-tree multiplier: two carry-save
// reduction layers followed by a single carry-propagate add.
module wallace_multiplier
  import wallace_pkg::*;
(
  input  logic [OPW-1:0]   a,
  input  logic [OPW-1:0]   b,
  output logic [PRODW-1:0] product
);

  // pp[r][c] = a[c] & b[r], weight r+c
  logic [OPW-1:0] pp [OPW];

  logic [1:0] h1a, f2a, f3a, f4a, h5a;
  logic [1:0] h2b, f3b, h4b, h5b, h6b;
  logic [PRODW-1:0] row_s, row_c;

  always_comb begin
    for (int r = 0; r < OPW; r++) begin
      pp[r] = a & {OPW{b[r]}};
    end
  end

  // Layer 1 reduces column heights 1,2,3,4,3,2,1 to at most 3.
  assign h1a = half_add(pp[0][1], pp[1][0]);
  assign f2a = full_add(pp[0][2], pp[1][1], pp[2][0]);
  assign f3a = full_add(pp[0][3], pp[1][2], pp[2][1]);
  assign f4a = full_add(pp[1][3], pp[2][2], pp[3][1]);
  assign h5a = half_add(pp[2][3], pp[3][2]);

  // Layer 2 leaves exactly two rows.
  assign h2b = half_add(f2a[0], h1a[1]);
  assign f3b = full_add(f3a[0], pp[3][0], f2a[1]);
  assign h4b = half_add(f4a[0], f3a[1]);
  assign h5b = half_add(h5a[0], f4a[1]);
  assign h6b = half_add(pp[3][3], h5a[1]);

  assign row_s = {h6b[1], h6b[0], h5b[0], h4b[0], f3b[0], h2b[0], h1a[0], pp[0][0]};
  assign row_c = {1'b0, h5b[1], h4b[1], f3b[1], h2b[1], 3'b000};

  assign product = row_s + row_c;

endmodule

// File: rtl/wallace_mac.sv
// Multiply-accumulate stage: registers each Wallace product, sums a group of
// products up to the pair tagged last, then holds the result until consumed.
module wallace_mac
  import wallace_pkg::*;
#(
  parameter int ACC_W = 12,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OPW-1:0]   a,
  input  logic [OPW-1:0]   b,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf
);

  mac_state_t       state;
  logic [PRODW-1:0] product;
  logic [PRODW-1:0] p_prod;
  logic             p_last;
  logic             p_valid;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic             ovf;
  logic [ACC_W:0]   sum;
  logic [ACC_W-1:0] new_acc;
  logic [CNT_W-1:0] new_cnt;
  logic             new_ovf;
  logic             capture;
  logic             p_consume;

  wallace_multiplier u_mult (
    .a       (a),
    .b       (b),
    .product (product)
  );

  // The product register may refill in HOLD only while it is empty.
  assign in_ready  = !p_valid || (state == ACC);
  assign capture   = in_valid && in_ready;
  assign p_consume = p_valid && (state == ACC);

  assign sum     = {1'b0, acc} + {{(ACC_W + 1 - PRODW){1'b0}}, p_prod};
  assign new_acc = sum[ACC_W-1:0];
  assign new_ovf = ovf | sum[ACC_W];
  assign new_cnt = (&cnt) ? cnt : cnt + CNT_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ACC;
      p_prod    <= '0;
      p_last    <= 1'b0;
      p_valid   <= 1'b0;
      acc       <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_count <= '0;
      out_ovf   <= 1'b0;
    end else begin
      if (capture) begin
        p_prod  <= product;
        p_last  <= in_last;
        p_valid <= 1'b1;
      end else if (p_consume) begin
        p_valid <= 1'b0;
      end

      case (state)
        ACC: begin
          if (p_consume) begin
            if (p_last) begin
              out_data  <= new_acc;
              out_count <= new_cnt;
              out_ovf   <= new_ovf;
              out_valid <= 1'b1;
              acc       <= '0;
              cnt       <= '0;
              ovf       <= 1'b0;
              state     <= HOLD;
            end else begin
              acc <= new_acc;
              cnt <= new_cnt;
              ovf <= new_ovf;
            end
          end
        end
        HOLD: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            state     <= ACC;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wallace_mac.sv
// Scoreboard bench for wallace_mac: directed and random groups are scored
// against an exact integer dot-product model.
module tb_wallace_mac;

  localparam int     ACC_W   = 12;
  localparam int     CNT_W   = 8;
  localparam longint ACC_MOD = 64'd1 << ACC_W;
  localparam int     CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       a;
  logic [3:0]       b;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_data;
  logic [CNT_W-1:0] out_count;
  logic             out_ovf;

  typedef struct {
    logic [ACC_W-1:0] data;
    logic [CNT_W-1:0] count;
    logic             ovf;
  } result_t;

  result_t exp_q[$];
  int      tests = 0;
  int      fails = 0;
  longint  grp_sum = 0;
  int      grp_cnt = 0;
  int      stall_total = 0;
  logic    rand_ready = 1'b0;
  logic    hold_ready = 1'b1;

  wallace_mac #(
    .ACC_W (ACC_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_count (out_count),
    .out_ovf   (out_ovf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #2;
    out_ready = rand_ready ? 1'($urandom_range(0, 1)) : hold_ready;
  end

  task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, got, want, $time);
    end
  endtask

  // Exact-arithmetic model: the group total is kept unbounded, then reduced.
  task automatic modelAccept(input logic [3:0] av, input logic [3:0] bv, input logic lv);
    result_t r;
    grp_sum += longint'(av) * longint'(bv);
    grp_cnt++;
    if (lv) begin
      r.data  = ACC_W'(grp_sum % ACC_MOD);
      r.count = CNT_W'((grp_cnt > CNT_MAX) ? CNT_MAX : grp_cnt);
      r.ovf   = (grp_sum >= ACC_MOD);
      exp_q.push_back(r);
      grp_sum = 0;
      grp_cnt = 0;
    end
  endtask

  task automatic modelReset();
    exp_q.delete();
    grp_sum = 0;
    grp_cnt = 0;
  endtask

  task automatic applyStimulus(input logic [3:0] av, input logic [3:0] bv, input logic lv);
    int   waited;
    logic accepted;
    waited   = 0;
    accepted = 1'b0;
    a = av;
    b = bv;
    in_last  = lv;
    in_valid = 1'b1;
    while (!accepted && waited < 300) begin
      @(negedge clk);
      if (in_ready) accepted = 1'b1;
      else begin
        waited++;
        stall_total++;
      end
    end
    if (accepted) modelAccept(av, bv, lv);
    else checkOutput("in_ready_timeout", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic waitOutValid();
    int n;
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("wait_out_valid", 64'(out_valid), 64'd1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    rand_ready = 1'b0;
    hold_ready = 1'b1;
    in_valid   = 1'b0;
    while (exp_q.size() != 0 && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("drain_pending", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic checkZeroOutputs(input string tag);
    checkOutput({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    checkOutput({tag, "_out_data"},  64'(out_data),  64'd0);
    checkOutput({tag, "_out_count"}, 64'(out_count), 64'd0);
    checkOutput({tag, "_out_ovf"},   64'(out_ovf),   64'd0);
  endtask

  // Monitor: every presented result is compared with the scoreboard head,
  // which also proves the result stays stable while it is held.
  always @(negedge clk) begin
    if (rst === 1'b0 && out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("[TB] FAIL unexpected_result: got data %0d, expected no result", out_data);
      end else begin
        checkOutput("out_data",  64'(out_data),  64'(exp_q[0].data));
        checkOutput("out_count", 64'(out_count), 64'(exp_q[0].count));
        checkOutput("out_ovf",   64'(out_ovf),   64'(exp_q[0].ovf));
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #600000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int len;
    rst       = 1'b1;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    #1;
    checkZeroOutputs("reset");
    checkOutput("reset_in_ready", 64'(in_ready), 64'd1);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    idle(1);

    // Single pair and its two-cycle latency.
    applyStimulus(4'd13, 4'd12, 1'b1);
    @(negedge clk);
    checkOutput("latency_edge1", 64'(out_valid), 64'd0);
    @(negedge clk);
    checkOutput("latency_edge2", 64'(out_valid), 64'd1);
    @(posedge clk);
    #1;

    // Back-to-back group with in_valid held high.
    stall_total = 0;
    applyStimulus(4'd13, 4'd12, 1'b0);
    applyStimulus(4'd13, 4'd13, 1'b0);
    applyStimulus(4'd9,  4'd12, 1'b1);
    checkOutput("b2b_stalls", 64'(stall_total), 64'd0);
    drain();

    // Consumer stalls: one pair may wait in P, then input back-pressures.
    hold_ready = 1'b0;
    fork
      begin
        applyStimulus(4'd3, 4'd4, 1'b1);
        applyStimulus(4'd2, 4'd3, 1'b0);
        applyStimulus(4'd4, 4'd5, 1'b1);
      end
      begin
        waitOutValid();
        for (int i = 0; i < 5; i++) begin
          if (i > 0) @(negedge clk);
          checkOutput("hold_in_ready", 64'(in_ready), 64'd0);
        end
        @(posedge clk);
        #1;
        hold_ready = 1'b1;
      end
    join
    drain();

    // Wrap and sticky overflow, then a clean group.
    for (int i = 0; i < 20; i++) applyStimulus(4'd15, 4'd15, i == 19);
    applyStimulus(4'd1, 4'd1, 1'b1);
    drain();

    // Pair count saturates.
    for (int i = 0; i < 300; i++)
      applyStimulus(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), i == 299);
    drain();

    // Reset mid-group discards the partial sum.
    applyStimulus(4'd7, 4'd7, 1'b0);
    applyStimulus(4'd3, 4'd3, 1'b0);
    rst = 1'b1;
    modelReset();
    #1;
    checkZeroOutputs("rst_group");
    @(posedge clk);
    #1;
    rst = 1'b0;
    applyStimulus(4'd2, 4'd3, 1'b1);
    drain();

    // Reset in HOLD discards the held result and the pending pair.
    hold_ready = 1'b0;
    applyStimulus(4'd7, 4'd7, 1'b1);
    applyStimulus(4'd3, 4'd3, 1'b0);
    waitOutValid();
    @(posedge clk);
    #1;
    rst = 1'b1;
    modelReset();
    #1;
    checkZeroOutputs("rst_hold");
    checkOutput("rst_hold_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    hold_ready = 1'b1;
    applyStimulus(4'd2, 4'd3, 1'b1);
    drain();

    // Output accept and input capture on the same edge.
    hold_ready = 1'b0;
    applyStimulus(4'd1, 4'd1, 1'b1);
    waitOutValid();
    @(posedge clk);
    #1;
    hold_ready  = 1'b1;
    stall_total = 0;
    applyStimulus(4'd5, 4'd5, 1'b1);
    hold_ready = 1'b0;
    @(negedge clk);
    checkOutput("sim_out_consumed", 64'(out_valid), 64'd0);
    checkOutput("sim_stalls", 64'(stall_total), 64'd0);
    @(posedge clk);
    #1;
    idle(4);
    drain();

    // Random groups with random consumer back-pressure.
    rand_ready = 1'b1;
    for (int g = 0; g < 150; g++) begin
      len = $urandom_range(1, 6);
      for (int i = 0; i < len; i++)
        applyStimulus(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), i == len - 1);
      idle($urandom_range(0, 2));
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
